// File: rtl/jt03_slot_seq_if.sv
// Slot-serial operator bus between the slot sequencer and its neighbours.
// Master issues slots and emits aligned results; slave returns op results.
interface jt03_slot_seq_if #(
  parameter int W = 14
);
  logic [1:0]          iss_ch;
  logic [1:0]          iss_op;
  logic signed [W-1:0] op_in;
  logic signed [W-1:0] op_result;
  logic                s1_enters;
  logic                s2_enters;
  logic                s3_enters;
  logic                s4_enters;
  logic                zero;
  logic [2:0]          alg;

  modport master (
    output iss_ch,
    output iss_op,
    input  op_in,
    output op_result,
    output s1_enters,
    output s2_enters,
    output s3_enters,
    output s4_enters,
    output zero,
    output alg
  );

  modport slave (
    input  iss_ch,
    input  iss_op,
    output op_in,
    input  op_result,
    input  s1_enters,
    input  s2_enters,
    input  s3_enters,
    input  s4_enters,
    input  zero,
    input  alg
  );
endinterface

// File: rtl/jt03_slot_seq.sv
// YM2203 12-slot sequencer: issues slots, holds per-channel algorithms
// and realigns operator results with their slot flags.
module jt03_slot_seq #(
  parameter int W      = 14,
  parameter int OP_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cfg_we,
  input  logic [1:0] cfg_ch,
  input  logic [2:0] cfg_alg,
  jt03_slot_seq_if.master bus
);

  typedef struct packed {
    logic       s1;
    logic       s2;
    logic       s3;
    logic       s4;
    logic       zero;
    logic [2:0] alg;
  } tag_t;

  logic [3:0] slot;
  logic [1:0] grp;
  logic [1:0] ch;
  logic [2:0] alg_r [3];
  logic [2:0] alg_sel;
  tag_t       iss_tag;
  tag_t       dly [OP_DLY];
  logic signed [W-1:0] res_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= 4'd0;
    end else if (clk_en) begin
      slot <= (slot == 4'd11) ? 4'd0 : slot + 4'd1;
    end
  end

  // group-major frame: slot/3 is the operator group, slot%3 the channel
  always_comb begin
    grp = 2'd0;
    ch  = 2'd0;
    unique case (1'b1)
      (slot <= 4'd2): begin
        grp = 2'd0;
        ch  = slot[1:0];
      end
      (slot >= 4'd3 && slot <= 4'd5): begin
        grp = 2'd1;
        ch  = 2'(slot - 4'd3);
      end
      (slot >= 4'd6 && slot <= 4'd8): begin
        grp = 2'd2;
        ch  = 2'(slot - 4'd6);
      end
      (slot >= 4'd9): begin
        grp = 2'd3;
        ch  = 2'(slot - 4'd9);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alg_r[0] <= 3'd0;
      alg_r[1] <= 3'd0;
      alg_r[2] <= 3'd0;
    end else if (cfg_we) begin
      unique case (cfg_ch)
        2'd0: alg_r[0] <= cfg_alg;
        2'd1: alg_r[1] <= cfg_alg;
        2'd2: alg_r[2] <= cfg_alg;
        2'd3: ;
      endcase
    end
  end

  always_comb begin
    alg_sel = 3'd0;
    unique case (ch)
      2'd0: alg_sel = alg_r[0];
      2'd1: alg_sel = alg_r[1];
      2'd2: alg_sel = alg_r[2];
      2'd3: alg_sel = 3'd0;
    endcase
  end

  // operator order within a frame is S1, S3, S2, S4
  always_comb begin
    iss_tag      = '0;
    iss_tag.s1   = (grp == 2'd0);
    iss_tag.s3   = (grp == 2'd1);
    iss_tag.s2   = (grp == 2'd2);
    iss_tag.s4   = (grp == 2'd3);
    iss_tag.zero = (slot == 4'd0);
    iss_tag.alg  = alg_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OP_DLY; i++) begin
        dly[i] <= '0;
      end
    end else if (clk_en) begin
      dly[0] <= iss_tag;
      for (int i = 1; i < OP_DLY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= '0;
    end else if (clk_en) begin
      res_r <= bus.op_in;
    end
  end

  assign bus.iss_ch    = ch;
  assign bus.iss_op    = grp;
  assign bus.op_result = res_r;
  assign bus.s1_enters = dly[OP_DLY-1].s1;
  assign bus.s2_enters = dly[OP_DLY-1].s2;
  assign bus.s3_enters = dly[OP_DLY-1].s3;
  assign bus.s4_enters = dly[OP_DLY-1].s4;
  assign bus.zero      = dly[OP_DLY-1].zero;
  assign bus.alg       = dly[OP_DLY-1].alg;

endmodule

// File: tb/tb_jt03_slot_seq.sv
// Directed bench for jt03_slot_seq with OP_DLY=2: frame order,
// alignment, algorithm capture, clock gating and mid-frame reset.
module tb_jt03_slot_seq;
  localparam int W = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [2:0] cfg_alg = 3'd0;

  jt03_slot_seq_if #(.W(W)) bus ();

  jt03_slot_seq #(.W(W), .OP_DLY(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_alg (cfg_alg),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int a1 = 0;
  int a2_k = 1000;

  task automatic ck(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic zero_all();
    ck("rst_iss_ch", int'(bus.iss_ch), 0);
    ck("rst_iss_op", int'(bus.iss_op), 0);
    ck("rst_flags", int'({bus.s1_enters, bus.s2_enters,
                          bus.s3_enters, bus.s4_enters}), 0);
    ck("rst_zero", int'(bus.zero), 0);
    ck("rst_alg", int'(bus.alg), 0);
    ck("rst_result", int'(bus.op_result), 0);
  endtask

  // k = clk_en edges since reset release; outputs depend only on k
  task automatic chk_all();
    int s;
    int g;
    int c;
    int ea;
    int fl [4];
    fl = '{8, 2, 4, 1};
    s = k % 12;
    ck("iss_ch", int'(bus.iss_ch), s % 3);
    ck("iss_op", int'(bus.iss_op), s / 3);
    if (k < 2) begin
      ck("bub_flags", int'({bus.s1_enters, bus.s2_enters,
                            bus.s3_enters, bus.s4_enters}), 0);
      ck("bub_zero", int'(bus.zero), 0);
      ck("bub_alg", int'(bus.alg), 0);
      ck("bub_result", int'(bus.op_result), 0);
    end else begin
      s = (k - 2) % 12;
      g = s / 3;
      c = s % 3;
      ea = 0;
      if (c == 1) ea = a1;
      if (c == 2 && (k - 2) >= a2_k) ea = 7;
      ck("flags", int'({bus.s1_enters, bus.s2_enters,
                        bus.s3_enters, bus.s4_enters}), fl[g]);
      ck("zero", int'(bus.zero), (s == 0) ? 1 : 0);
      ck("alg", int'(bus.alg), ea);
      ck("op_result", int'(bus.op_result), s + 100);
    end
  endtask

  task automatic cyc(input bit en);
    clk_en = en;
    bus.op_in = (k >= 1) ? W'((k - 1) % 12 + 100) : '0;
    @(posedge clk);
    #1;
    if (en) k++;
    chk_all();
  endtask

  initial begin
    bus.op_in = '0;
    repeat (2) @(posedge clk);
    #1;
    zero_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all();

    cfg_we = 1'b1;
    cfg_ch = 2'd1;
    cfg_alg = 3'd5;
    cyc(1'b0);
    a1 = 5;
    cfg_ch = 2'd3;
    cfg_alg = 3'd6;
    cyc(1'b0);
    cfg_we = 1'b0;

    for (int i = 0; i < 30; i++) begin
      if (k == 17) begin
        cfg_we = 1'b1;
        cfg_ch = 2'd2;
        cfg_alg = 3'd7;
        a2_k = 18;
      end
      cyc(1'b1);
      cfg_we = 1'b0;
    end

    for (int i = 0; i < 36; i++) begin
      cyc(i % 3 == 0);
    end

    for (int i = 0; i < 12 && (k % 12) != 7; i++) begin
      cyc(1'b1);
    end
    ck("pre_rst_slot", int'(bus.iss_op) * 3 + int'(bus.iss_ch), 7);

    rst_n = 1'b0;
    #1;
    zero_all();
    @(posedge clk);
    #1;
    zero_all();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    a1 = 0;
    a2_k = 1000;
    #1;
    chk_all();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
